// File: rtl/axis_spi_slave_rx_if.sv
// SPI pins plus receive/response AXI-Stream buses of the SPI responder.
// slave = the responder itself; master = SPI master and AXI-Stream endpoints.
interface axis_spi_slave_rx_if;
  logic        sck;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        overflow;
  logic        frame_err;

  modport slave (
    input  sck, cs_n, mosi, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    output miso, miso_oe, m_axis_tdata, m_axis_tvalid, s_axis_tready, overflow, frame_err
  );

  modport master (
    output sck, cs_n, mosi, m_axis_tready, s_axis_tdata, s_axis_tvalid,
    input  miso, miso_oe, m_axis_tdata, m_axis_tvalid, s_axis_tready, overflow, frame_err
  );
endinterface

// File: rtl/axis_spi_slave_rx.sv
// Mode-0 SPI responder: oversampled SCK/CS_N/MOSI deserialised to AXI-Stream; response word shifted out on MISO.
// Word valid SYNC_STAGES+2 clk after the final SCK rise is sampled; a word completing while the output is stalled is dropped (overflow).
module axis_spi_slave_rx #(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input logic                clk,
  input logic                aresetn,
  axis_spi_slave_rx_if.slave bus
);
  localparam int W  = SPI_DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic r_sck_hist, r_cs_hist;
  logic r_sck_rise, r_sck_fall, r_cs_rise, r_cs_fall, r_mosi_bit;

  logic [W-2:0]  r_rx_shift;
  logic [W-1:0]  r_tx_shift, r_tx_hold, r_word;
  logic [CW-1:0] r_bit_cnt;
  logic          r_word_done, r_tx_full, r_miso, r_miso_oe;
  logic [31:0]   r_tdata;
  logic          r_tvalid, r_overflow, r_frame_err;

  logic          w_rx_en, w_tx_en, w_frame_start, w_frame_end;
  logic          w_consume, w_load, w_last, w_unused;
  logic [W-1:0]  w_word, w_tx_next;

  // Edge pulses and the MOSI sample are registered together so they stay aligned.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_hist  <= 1'b0;
      r_cs_hist   <= 1'b1;
      r_sck_rise  <= 1'b0;
      r_sck_fall  <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_mosi_bit  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sck_hist  <= r_sck_sync[SYNC_STAGES-1];
      r_cs_hist   <= r_cs_sync[SYNC_STAGES-1];
      r_sck_rise  <= r_sck_sync[SYNC_STAGES-1] & ~r_sck_hist;
      r_sck_fall  <= ~r_sck_sync[SYNC_STAGES-1] & r_sck_hist;
      r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_hist;
      r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_hist;
      r_mosi_bit  <= r_mosi_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rx_en       = 1'b0;
    w_tx_en       = 1'b0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cs_fall) begin
          w_frame_start = 1'b1;
          w_state_nxt   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_rx_en = r_sck_rise;
        w_tx_en = r_sck_fall;
        if (r_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_word    = {r_rx_shift, r_mosi_bit};
  assign w_last    = (r_bit_cnt == CW'(W - 1));
  assign w_tx_next = r_tx_full ? r_tx_hold : '0;
  // A falling SCK with bit_cnt==0 inside a frame can only follow a completed word.
  assign w_consume = w_frame_start | (w_tx_en & (r_bit_cnt == '0));
  assign w_load    = bus.s_axis_tvalid & ~r_tx_full;
  assign w_unused  = ^bus.s_axis_tdata;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_tx_hold   <= '0;
      r_tx_full   <= 1'b0;
      r_word      <= '0;
      r_word_done <= 1'b0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      r_frame_err <= w_frame_end & (r_bit_cnt != '0);
      if (w_load) r_tx_hold <= bus.s_axis_tdata[W-1:0];
      r_tx_full <= w_load | (r_tx_full & ~w_consume);
      if (w_frame_start) begin
        r_bit_cnt  <= '0;
        r_tx_shift <= w_tx_next;
        r_miso     <= w_tx_next[W-1];
        r_miso_oe  <= 1'b1;
      end else if (w_frame_end) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else begin
        if (w_rx_en) begin
          r_rx_shift <= w_word[W-2:0];
          if (w_last) begin
            r_bit_cnt   <= '0;
            r_word      <= w_word;
            r_word_done <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        if (w_tx_en) begin
          if (r_bit_cnt == '0) begin
            r_tx_shift <= w_tx_next;
            r_miso     <= w_tx_next[W-1];
          end else begin
            r_tx_shift <= r_tx_shift << 1;
            r_miso     <= r_tx_shift[W-2];
          end
        end
      end
    end
  end

  // A word completing on the handshake cycle replaces the departing beat.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_word_done) begin
        if (!r_tvalid || bus.m_axis_tready) begin
          r_tdata  <= 32'(r_word);
          r_tvalid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (bus.m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign bus.miso          = r_miso;
  assign bus.miso_oe       = r_miso_oe;
  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.s_axis_tready = ~r_tx_full;
  assign bus.overflow      = r_overflow;
  assign bus.frame_err     = r_frame_err;
endmodule
